// File: rtl/dispatch_unit.sv
// Rename/dispatch stage: pops a free tag for every dispatched instruction, resolves
// source operands against the register status table, register file and CDB, and retires tags on CDB.

module dispatch_operand (
    input  logic [4:0]  rs,
    input  logic        busy,
    input  logic [5:0]  map_tag,
    input  logic [31:0] rf_data,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    output logic [31:0] data,
    output logic [5:0]  tag,
    output logic        pending
);
    always_comb begin
        data    = rf_data;
        tag     = map_tag;
        pending = 1'b0;
        if (rs == 5'd0) begin
            data = '0;
        end else if (busy && cdb_valid && (cdb_tag == map_tag)) begin
            // producer is broadcasting right now; its result never reaches the RF in time
            data = cdb_data;
        end else if (busy) begin
            data    = '0;
            pending = 1'b1;
        end
    end
endmodule

module dispatch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [1:0]  instr_unit,
    input  logic [4:0]  instr_opcode,
    input  logic [4:0]  instr_rd,
    input  logic        instr_rd_we,
    input  logic [4:0]  instr_rs1,
    input  logic [4:0]  instr_rs2,
    input  logic        instr_use_imm,
    input  logic [31:0] instr_imm,
    input  logic        issueque_full_integer,
    input  logic        issueque_full_ld_st,
    input  logic        issueque_full_mul,
    input  logic        issueque_full_div,
    input  logic        CDB_valid,
    input  logic [5:0]  CDB_tag,
    input  logic [31:0] CDB_data,
    output logic        dispatch_en_integer,
    output logic        dispatch_en_ld_st,
    output logic        dispatch_en_mul,
    output logic        dispatch_en_div,
    output logic [4:0]  dispatch_opcode,
    output logic [5:0]  dispatch_rd_tag,
    output logic [31:0] dispatch_rs1_data,
    output logic [31:0] dispatch_rs2_data,
    output logic [5:0]  dispatch_rs1_tag,
    output logic [5:0]  dispatch_rs2_tag,
    output logic        dispatch_rs1_valid,
    output logic        dispatch_rs2_valid,
    output logic [31:0] dispatch_imm,
    output logic [6:0]  tag_free_count
);
    localparam int NUM_SRC  = 2;
    localparam int NUM_TAGS = 64;
    localparam int NUM_REGS = 32;

    logic [5:0]  fifo_mem [NUM_TAGS];
    logic [5:0]  rd_ptr, wr_ptr;
    logic [6:0]  count;

    logic [NUM_REGS-1:0] busy;
    logic [5:0]          map_tag [NUM_REGS];
    logic [31:0]         rf      [NUM_REGS];

    logic [3:0]  unit_full;
    logic [3:0]  unit_sel;
    logic        fire, push, pop, rd_alloc;
    logic [5:0]  pop_tag;

    logic [NUM_SRC-1:0][4:0]  src_idx;
    logic [NUM_SRC-1:0][31:0] src_data;
    logic [NUM_SRC-1:0][5:0]  src_tag;
    logic [NUM_SRC-1:0]       src_pend;

    assign unit_full   = {issueque_full_div, issueque_full_mul, issueque_full_ld_st, issueque_full_integer};
    assign unit_sel    = 4'b0001 << instr_unit;
    assign instr_ready = reset && !unit_full[instr_unit] && (count != 7'd0);
    assign fire        = instr_valid && instr_ready;
    assign pop         = fire;
    // a full pool means the back-end broadcast a tag it never owned; drop it
    assign push        = CDB_valid && (count != 7'(NUM_TAGS));
    assign pop_tag     = fifo_mem[rd_ptr];
    assign rd_alloc    = fire && instr_rd_we && (instr_rd != 5'd0);

    assign {dispatch_en_div, dispatch_en_mul, dispatch_en_ld_st, dispatch_en_integer} =
        fire ? unit_sel : 4'b0000;

    assign src_idx = {instr_rs2, instr_rs1};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        dispatch_operand u_op (
            .rs        (src_idx[g]),
            .busy      (busy[src_idx[g]]),
            .map_tag   (map_tag[src_idx[g]]),
            .rf_data   (rf[src_idx[g]]),
            .cdb_valid (CDB_valid),
            .cdb_tag   (CDB_tag),
            .cdb_data  (CDB_data),
            .data      (src_data[g]),
            .tag       (src_tag[g]),
            .pending   (src_pend[g])
        );
    end

    assign dispatch_opcode    = instr_opcode;
    assign dispatch_rd_tag    = pop_tag;
    assign dispatch_imm       = instr_imm;
    assign dispatch_rs1_data  = src_data[0];
    assign dispatch_rs1_tag   = src_tag[0];
    assign dispatch_rs1_valid = src_pend[0];

    always_comb begin
        dispatch_rs2_data  = src_data[1];
        dispatch_rs2_tag   = src_tag[1];
        dispatch_rs2_valid = src_pend[1];
        if (instr_use_imm && (instr_unit == 2'b00)) begin
            dispatch_rs2_data  = instr_imm;
            dispatch_rs2_valid = 1'b0;
        end
    end

    assign tag_free_count = count;

    // Free-tag FIFO; reset preloads every tag so the pool starts full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_TAGS; i++) fifo_mem[i] <= 6'(i);
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 7'(NUM_TAGS);
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= CDB_tag;
                wr_ptr           <= wr_ptr + 6'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 6'd1;
            if (push && !pop)      count <= count + 7'd1;
            else if (pop && !push) count <= count - 7'd1;
        end
    end

    // RST and RF; the rename write comes last so it wins over a same-cycle CDB clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                map_tag[r] <= '0;
                rf[r]      <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (CDB_valid && busy[r] && (map_tag[r] == CDB_tag)) begin
                    rf[r]   <= CDB_data;
                    busy[r] <= 1'b0;
                end
                if (rd_alloc && (instr_rd == 5'(r))) begin
                    busy[r]    <= 1'b1;
                    map_tag[r] <= pop_tag;
                end
            end
        end
    end
endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: stimulus queues expected dispatches, a negedge monitor checks them.

module tb_dispatch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [1:0]  instr_unit = '0;
    logic [4:0]  instr_opcode = '0;
    logic [4:0]  instr_rd = '0;
    logic        instr_rd_we = 1'b0;
    logic [4:0]  instr_rs1 = '0;
    logic [4:0]  instr_rs2 = '0;
    logic        instr_use_imm = 1'b0;
    logic [31:0] instr_imm = '0;
    logic        issueque_full_integer = 1'b0;
    logic        issueque_full_ld_st = 1'b0;
    logic        issueque_full_mul = 1'b0;
    logic        issueque_full_div = 1'b0;
    logic        CDB_valid = 1'b0;
    logic [5:0]  CDB_tag = '0;
    logic [31:0] CDB_data = '0;
    logic        dispatch_en_integer, dispatch_en_ld_st, dispatch_en_mul, dispatch_en_div;
    logic [4:0]  dispatch_opcode;
    logic [5:0]  dispatch_rd_tag;
    logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
    logic [5:0]  dispatch_rs1_tag, dispatch_rs2_tag;
    logic        dispatch_rs1_valid, dispatch_rs2_valid;
    logic [31:0] dispatch_imm;
    logic [6:0]  tag_free_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  unit;
        logic [4:0]  op;
        logic [5:0]  tag;
        logic        v1;
        logic [31:0] x1;
        logic        v2;
        logic [31:0] x2;
        logic [31:0] imm;
    } exp_t;

    exp_t exp_q[$];

    dispatch_unit dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_unit(instr_unit), .instr_opcode(instr_opcode),
        .instr_rd(instr_rd), .instr_rd_we(instr_rd_we),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
        .issueque_full_integer(issueque_full_integer), .issueque_full_ld_st(issueque_full_ld_st),
        .issueque_full_mul(issueque_full_mul), .issueque_full_div(issueque_full_div),
        .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
        .dispatch_en_integer(dispatch_en_integer), .dispatch_en_ld_st(dispatch_en_ld_st),
        .dispatch_en_mul(dispatch_en_mul), .dispatch_en_div(dispatch_en_div),
        .dispatch_opcode(dispatch_opcode), .dispatch_rd_tag(dispatch_rd_tag),
        .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
        .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs1_valid(dispatch_rs1_valid), .dispatch_rs2_valid(dispatch_rs2_valid),
        .dispatch_imm(dispatch_imm), .tag_free_count(tag_free_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Monitor: every dispatch strobe consumes one expected entry.
    always @(negedge clk) begin
        logic [3:0] en;
        exp_t e;
        en = {dispatch_en_div, dispatch_en_mul, dispatch_en_ld_st, dispatch_en_integer};
        if (en != 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_dispatch", 32'(en), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("dispatch_en", 32'(en), 32'(4'b0001 << e.unit));
                chk("rd_tag", 32'(dispatch_rd_tag), 32'(e.tag));
                chk("opcode", 32'(dispatch_opcode), 32'(e.op));
                chk("imm", dispatch_imm, e.imm);
                chk("rs1_valid", 32'(dispatch_rs1_valid), 32'(e.v1));
                if (e.v1) chk("rs1_tag", 32'(dispatch_rs1_tag), e.x1);
                else      chk("rs1_data", dispatch_rs1_data, e.x1);
                chk("rs2_valid", 32'(dispatch_rs2_valid), 32'(e.v2));
                if (e.v2) chk("rs2_tag", 32'(dispatch_rs2_tag), e.x2);
                else      chk("rs2_data", dispatch_rs2_data, e.x2);
            end
        end
    end

    // Drive one instruction for the current cycle and queue what it must produce.
    // x1/x2 are the expected tag when v1/v2 is 1, otherwise the expected data.
    task automatic issue(input logic [1:0] u, input logic [4:0] rd, input logic we,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic ui, input logic [31:0] imm, input logic [5:0] tag,
                         input logic v1, input logic [31:0] x1,
                         input logic v2, input logic [31:0] x2);
        exp_t e;
        instr_valid   = 1'b1;
        instr_unit    = u;
        instr_opcode  = 5'(tag) + 5'd3;
        instr_rd      = rd;
        instr_rd_we   = we;
        instr_rs1     = rs1;
        instr_rs2     = rs2;
        instr_use_imm = ui;
        instr_imm     = imm;
        e.unit = u; e.op = 5'(tag) + 5'd3; e.tag = tag;
        e.v1 = v1; e.x1 = x1; e.v2 = v2; e.x2 = x2; e.imm = imm;
        exp_q.push_back(e);
    endtask

    task automatic cdb(input logic [5:0] t, input logic [31:0] d);
        CDB_valid = 1'b1;
        CDB_tag   = t;
        CDB_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        instr_valid   = 1'b0;
        instr_use_imm = 1'b0;
        CDB_valid     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // in reset: full pool, never ready
        instr_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_count", 32'(tag_free_count), 32'd64);
        chk("reset_ready", 32'(instr_ready), 32'd0);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        reset = 1'b1;

        // ADD x3 <- x1, x2
        issue(2'd0, 5'd3, 1'b1, 5'd1, 5'd2, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("count_after_first", 32'(tag_free_count), 32'd63);

        // MUL x4 <- x3, x3; imm on a non-int unit must not replace rs2
        issue(2'd2, 5'd4, 1'b1, 5'd3, 5'd3, 1'b1, 32'hDEAD, 6'd1, 1'b1, 32'd0, 1'b1, 32'd0);
        tick();
        chk("count_after_mul", 32'(tag_free_count), 32'd62);

        // x5 <- x3, x4 while tag 0 broadcasts: rs1 bypassed, rs2 still waits on tag 1
        issue(2'd0, 5'd5, 1'b1, 5'd3, 5'd4, 1'b0, 32'h0, 6'd2, 1'b0, 32'h1234, 1'b1, 32'd1);
        cdb(6'd0, 32'h1234);
        tick();
        chk("count_push_pop", 32'(tag_free_count), 32'd62);

        // x6 <- x3 (now in RF), imm
        issue(2'd0, 5'd6, 1'b1, 5'd3, 5'd9, 1'b1, 32'hABCD, 6'd3, 1'b0, 32'h1234, 1'b0, 32'hABCD);
        tick();
        chk("count_after_imm", 32'(tag_free_count), 32'd61);

        // div queue full: stalled
        issueque_full_div = 1'b1;
        instr_valid = 1'b1; instr_unit = 2'd3; instr_rd = 5'd8; instr_rd_we = 1'b1;
        @(negedge clk);
        chk("div_full_ready", 32'(instr_ready), 32'd0);
        tick();
        chk("count_after_stall", 32'(tag_free_count), 32'd61);

        // int still flows with div full; x7 -> tag 4
        issue(2'd0, 5'd7, 1'b1, 5'd0, 5'd0, 1'b0, 32'h0, 6'd4, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        issueque_full_div = 1'b0;

        // remap x7 -> tag 5 while old tag 4 broadcasts
        issue(2'd0, 5'd7, 1'b1, 5'd7, 5'd0, 1'b0, 32'h0, 6'd5, 1'b0, 32'h5555, 1'b0, 32'h0);
        cdb(6'd4, 32'h5555);
        tick();
        chk("count_remap", 32'(tag_free_count), 32'd60);

        // x7 must still be mapped to tag 5
        issue(2'd1, 5'd9, 1'b1, 5'd7, 5'd7, 1'b0, 32'h0, 6'd6, 1'b1, 32'd5, 1'b1, 32'd5);
        tick();
        cdb(6'd5, 32'h7777);
        tick();
        chk("count_cdb_only", 32'(tag_free_count), 32'd60);
        issue(2'd2, 5'd10, 1'b1, 5'd7, 5'd5, 1'b0, 32'h0, 6'd7, 1'b0, 32'h7777, 1'b1, 32'd2);
        tick();
        chk("count_pre_reset", 32'(tag_free_count), 32'd59);

        // asynchronous reset mid-stream
        reset = 1'b0;
        instr_valid = 1'b1; instr_unit = 2'd0;
        #1;
        chk("async_reset_count", 32'(tag_free_count), 32'd64);
        chk("async_reset_ready", 32'(instr_ready), 32'd0);
        tick();
        reset = 1'b1;

        // push into a full pool is ignored
        cdb(6'd33, 32'hFFFF);
        tick();
        chk("full_push_ignored", 32'(tag_free_count), 32'd64);

        // first dispatch after reset: tag 0, x7/x10 cleared
        issue(2'd0, 5'd1, 1'b1, 5'd7, 5'd10, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        for (int i = 1; i < 64; i++) begin
            issue(2'(i % 4), 5'(i), 1'b0, 5'd0, 5'd0, 1'b0, 32'(i), 6'(i), 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
        end
        chk("exhausted_count", 32'(tag_free_count), 32'd0);

        // pool empty: not ready even while a tag is being returned this cycle
        instr_valid = 1'b1; instr_unit = 2'd0;
        cdb(6'd5, 32'h0);
        @(negedge clk);
        chk("empty_ready", 32'(instr_ready), 32'd0);
        tick();
        chk("count_one", 32'(tag_free_count), 32'd1);

        // wrapped pointers hand back tag 5; x1 still waits on tag 0
        issue(2'd0, 5'd2, 1'b1, 5'd1, 5'd0, 1'b0, 32'h0, 6'd5, 1'b1, 32'd0, 1'b0, 32'h0);
        tick();
        chk("count_final", 32'(tag_free_count), 32'd0);

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
